// File: rtl/bcd_updown_counter_n.sv
// Multi-digit modulo-N up/down counter with parallel load, optional saturation, TC levels and wrap pulses.
// Latency: q/wrap pulses update on the edge that samples the request; tcu/tcd decode q combinationally.
// Backpressure: none, a request is accepted every cycle (load > up > down > hold).
module bcd_updown_counter_n #(
   parameter int DIGITS   = 4,
   parameter int MODULUS  = 10,
   parameter int SATURATE = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                up,
   input  logic                dn,
   input  logic                load,
   input  logic [4*DIGITS-1:0] d,
   output logic [4*DIGITS-1:0] q,
   output logic                tcu,
   output logic                tcd,
   output logic                wrap_up,
   output logic                wrap_dn
);

   localparam int         W    = 4*DIGITS;
   localparam logic [3:0] MAXD = 4'(MODULUS-1);

   logic [W-1:0] q_inc;
   logic [W-1:0] q_dec;
   logic         carry_out;
   logic         borrow_out;
   logic         do_inc;
   logic         do_dec;

   assign do_inc = en & up & ~dn;
   assign do_dec = en & dn & ~up;

   // Carry ripples from the LSD; any digit at or above MAXD (including invalid loads) rolls to 0.
   always_comb begin : inc_path
      logic       c;
      logic [3:0] dig;
      q_inc = q;
      c     = 1'b1;
      dig   = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         dig = q[4*i +: 4];
         if (c) begin
            if (dig >= MAXD) begin
               q_inc[4*i +: 4] = 4'd0;
            end else begin
               q_inc[4*i +: 4] = dig + 4'd1;
               c               = 1'b0;
            end
         end
      end
      carry_out = c;
   end

   // Only a zero digit borrows; an invalid digit simply steps down by one.
   always_comb begin : dec_path
      logic       b;
      logic [3:0] dig;
      q_dec = q;
      b     = 1'b1;
      dig   = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         dig = q[4*i +: 4];
         if (b) begin
            if (dig == 4'd0) begin
               q_dec[4*i +: 4] = MAXD;
            end else begin
               q_dec[4*i +: 4] = dig - 4'd1;
               b               = 1'b0;
            end
         end
      end
      borrow_out = b;
   end

   always_comb begin : tc_decode
      tcu = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (q[4*i +: 4] != MAXD) tcu = 1'b0;
      end
      tcd = (q == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q       <= '0;
         wrap_up <= 1'b0;
         wrap_dn <= 1'b0;
      end else begin
         wrap_up <= 1'b0;
         wrap_dn <= 1'b0;
         if (load) begin
            q <= d;
         end else if (do_inc) begin
            if (!(carry_out && SATURATE != 0)) begin
               q       <= q_inc;
               wrap_up <= carry_out;
            end
         end else if (do_dec) begin
            if (!(borrow_out && SATURATE != 0)) begin
               q       <= q_dec;
               wrap_dn <= borrow_out;
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Scoreboarded bench for bcd_updown_counter_n across BCD, saturating, binary-nibble and 1-digit BCD variants.
module tb_bcd_updown_counter_n;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, up, dn, load;
   logic [7:0] d8;

   logic [7:0] q_a, q_b;
   logic [3:0] q_c, q_d;
   logic       tcu_a, tcd_a, wu_a, wd_a;
   logic       tcu_b, tcd_b, wu_b, wd_b;
   logic       tcu_c, tcd_c, wu_c, wd_c;
   logic       tcu_d, tcd_d, wu_d, wd_d;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int         sel;
      string      tag;
      logic [7:0] q;
      logic       wu;
      logic       wd;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   bcd_updown_counter_n #(.DIGITS(2), .MODULUS(10), .SATURATE(0)) u_a (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .dn(dn), .load(load), .d(d8),
      .q(q_a), .tcu(tcu_a), .tcd(tcd_a), .wrap_up(wu_a), .wrap_dn(wd_a));

   bcd_updown_counter_n #(.DIGITS(2), .MODULUS(10), .SATURATE(1)) u_b (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .dn(dn), .load(load), .d(d8),
      .q(q_b), .tcu(tcu_b), .tcd(tcd_b), .wrap_up(wu_b), .wrap_dn(wd_b));

   bcd_updown_counter_n #(.DIGITS(1), .MODULUS(16), .SATURATE(0)) u_c (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .dn(dn), .load(load), .d(d8[3:0]),
      .q(q_c), .tcu(tcu_c), .tcd(tcd_c), .wrap_up(wu_c), .wrap_dn(wd_c));

   bcd_updown_counter_n #(.DIGITS(1), .MODULUS(10), .SATURATE(0)) u_d (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .dn(dn), .load(load), .d(d8[3:0]),
      .q(q_d), .tcu(tcu_d), .tcd(tcd_d), .wrap_up(wu_d), .wrap_dn(wd_d));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, want);
      end
   endtask

   task automatic observe(input int sel, output logic [7:0] oq, output logic otcu,
                          output logic otcd, output logic owu, output logic owd);
      case (sel)
         0:       begin oq = q_a;         otcu = tcu_a; otcd = tcd_a; owu = wu_a; owd = wd_a; end
         1:       begin oq = q_b;         otcu = tcu_b; otcd = tcd_b; owu = wu_b; owd = wd_b; end
         2:       begin oq = {4'h0, q_c}; otcu = tcu_c; otcd = tcd_c; owu = wu_c; owd = wd_c; end
         default: begin oq = {4'h0, q_d}; otcu = tcu_d; otcd = tcd_d; owu = wu_d; owd = wd_d; end
      endcase
   endtask

   // Terminal-count levels expected for a given variant and count value.
   function automatic logic want_tcu(input int sel, input logic [7:0] v);
      case (sel)
         0, 1:    return v == 8'h99;
         2:       return v[3:0] == 4'hF;
         default: return v[3:0] == 4'h9;
      endcase
   endfunction

   function automatic logic want_tcd(input int sel, input logic [7:0] v);
      return (sel < 2) ? (v == 8'h00) : (v[3:0] == 4'h0);
   endfunction

   task automatic compare_next();
      exp_t       e;
      logic [7:0] oq;
      logic       otcu, otcd, owu, owd;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      observe(e.sel, oq, otcu, otcd, owu, owd);
      chk({e.tag, ".q"},       {24'h0, oq}, {24'h0, e.q});
      chk({e.tag, ".wrap_up"}, {31'h0, owu}, {31'h0, e.wu});
      chk({e.tag, ".wrap_dn"}, {31'h0, owd}, {31'h0, e.wd});
      chk({e.tag, ".tcu"},     {31'h0, otcu}, {31'h0, want_tcu(e.sel, e.q)});
      chk({e.tag, ".tcd"},     {31'h0, otcd}, {31'h0, want_tcd(e.sel, e.q)});
   endtask

   // Drive one request on the falling edge, expect its effect just after the next rising edge.
   task automatic step(input int sel, input string tag, input logic ld, input logic [7:0] dv,
                       input logic e, input logic u, input logic dd,
                       input logic [7:0] eq, input logic ewu, input logic ewd);
      exp_t x;
      @(negedge clk);
      load = ld; d8 = dv; en = e; up = u; dn = dd;
      x.sel = sel; x.tag = tag; x.q = eq; x.wu = ewu; x.wd = ewd;
      sb.push_back(x);
      @(posedge clk);
      #1;
      compare_next();
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; up = 1'b0; dn = 1'b0; load = 1'b0; d8 = 8'h00;
      #3;
      chk("reset.q",   {24'h0, q_a}, 32'h0);
      chk("reset.tcd", {31'h0, tcd_a}, 32'h1);
      chk("reset.tcu", {31'h0, tcu_a}, 32'h0);
      chk("reset.wrap_up", {31'h0, wu_a}, 32'h0);
      chk("reset.wrap_dn", {31'h0, wd_a}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Mid-count asynchronous reset
      step(0, "ld36", 1'b1, 8'h36, 1'b0, 1'b0, 1'b0, 8'h36, 1'b0, 1'b0);
      step(0, "up37", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h37, 1'b0, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst.q",   {24'h0, q_a}, 32'h0);
      chk("midrst.tcd", {31'h0, tcd_a}, 32'h1);
      chk("midrst.wrap_up", {31'h0, wu_a}, 32'h0);
      chk("midrst.wrap_dn", {31'h0, wd_a}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1; en = 1'b0; up = 1'b0;
      step(0, "postrst_up", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);

      // Up wrap at all-max
      step(0, "ld99",    1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0);
      step(0, "up_wrap", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      step(0, "wu_clr",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Down wrap at zero and inter-digit borrow/carry
      step(0, "ld00",    1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      step(0, "dn_wrap", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
      step(0, "wd_clr",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0);
      step(0, "ld20",    1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0);
      step(0, "dn19",    1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h19, 1'b0, 1'b0);
      step(0, "up20",    1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0);

      // Hold cases and load priority
      step(0, "ld42",      1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0);
      step(0, "hold_updn", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0);
      step(0, "hold_en0",  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h42, 1'b0, 1'b0);
      step(0, "dn41",      1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0);
      step(0, "ld99b",     1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0);
      step(0, "ld_over_up", 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 8'h05, 1'b0, 1'b0);

      // Saturating variant
      step(1, "sat_ld99", 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         step(1, "sat_up", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
      step(1, "sat_dn98", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h98, 1'b0, 1'b0);
      step(1, "sat_ld00", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1, "sat_dn",   1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      step(1, "sat_up01", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);

      // Binary nibble variant
      step(2, "hex_ldF", 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0);
      step(2, "hex_up",  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      step(2, "hex_dn",  1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b1);

      // Invalid BCD digit self-correction
      step(3, "inv_ldC", 1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b0);
      step(3, "inv_up",  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      step(3, "inv_ldC2", 1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b0);
      step(3, "inv_dn",  1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h0B, 1'b0, 1'b0);
      step(3, "d_ld0",   1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      step(3, "d_dn",    1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h09, 1'b0, 1'b1);

      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
